// File: rtl/simon_pkg.sv
// Shared types and helpers for the Simon request arbiter.
`default_nettype none

package simon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_t;

    localparam int NREQ_MAX = 8;
    localparam int NREQ_W_MAX = $clog2(NREQ_MAX);

    // Width of a requester index; never below one bit.
    function automatic int owner_width(input int nreq);
        return (nreq < 2) ? 1 : $clog2(nreq);
    endfunction

endpackage

`default_nettype wire

// File: rtl/simon_rr_arb.sv
// Combinational round-robin picker: searches from last_grant+1 upward, wrapping.
`default_nettype none

module simon_rr_arb #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_grant,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    logic          found;
    logic [IW-1:0] pos;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        // i runs to N so the previous winner is considered last.
        for (int i = 1; i <= N; i++) begin
            pos = IW'((int'(last_grant) + i) % N);
            if (!found && req[pos]) begin
                found      = 1'b1;
                grant[pos] = 1'b1;
                idx        = pos;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/simon_req_arbiter.sv
// Serializes NREQ requesters onto one non-pipelined Simon engine, one operation in flight.
`default_nettype none

module simon_req_arbiter
    import simon_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int WW   = 32,
    parameter int NKW  = 4
) (
    input  logic                        clk,
    input  logic                        arst_n,
    input  logic [NREQ-1:0]             req_valid_i,
    output logic [NREQ-1:0]             req_ready_o,
    input  logic [NREQ-1:0]             req_mode_i,
    input  logic [NREQ*2*WW-1:0]        req_pt_i,
    input  logic [NREQ*NKW*WW-1:0]      req_key_i,
    output logic [NREQ-1:0]             rsp_valid_o,
    input  logic [NREQ-1:0]             rsp_ready_i,
    output logic                        rsp_mode_o,
    output logic [2*WW-1:0]             rsp_ct_o,
    output logic                        eng_valid_o,
    input  logic                        eng_ready_i,
    output logic                        eng_mode_o,
    output logic [2*WW-1:0]             eng_pt_o,
    output logic [NKW*WW-1:0]           eng_key_o,
    input  logic                        eng_valid_i,
    output logic                        eng_ready_o,
    input  logic                        eng_mode_i,
    input  logic [2*WW-1:0]             eng_ct_i,
    output logic                        busy_o,
    output logic [$clog2(NREQ)-1:0]     owner_o,
    output logic                        err_o
);

    localparam int OW = owner_width(NREQ);

    arb_state_t    state;
    logic [OW-1:0] owner;
    logic [OW-1:0] last_grant;
    logic [NREQ-1:0] owner_oh;
    logic          err;

    logic [NREQ-1:0] pick_oh;
    logic [OW-1:0]   pick_idx;

    simon_rr_arb #(
        .N  (NREQ),
        .IW (OW)
    ) u_rr (
        .req        (req_valid_i),
        .last_grant (last_grant),
        .grant      (pick_oh),
        .idx        (pick_idx)
    );

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state      <= ST_IDLE;
            owner      <= '0;
            owner_oh   <= '0;
            last_grant <= OW'(NREQ - 1);
            err        <= 1'b0;
        end else begin
            // Protocol violations latch until reset.
            if (eng_valid_i && state != ST_WAIT)
                err <= 1'b1;
            if (state == ST_ISSUE && !req_valid_i[owner])
                err <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (|req_valid_i) begin
                        owner    <= pick_idx;
                        owner_oh <= pick_oh;
                        state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (eng_ready_i)
                        state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (eng_valid_i && rsp_ready_i[owner]) begin
                        last_grant <= owner;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy_o  = (state != ST_IDLE);
    assign owner_o = owner;
    assign err_o   = err;

    assign eng_valid_o = (state == ST_ISSUE);
    assign eng_mode_o  = req_mode_i[owner];
    assign eng_pt_o    = req_pt_i[owner*2*WW +: 2*WW];
    assign eng_key_o   = req_key_i[owner*NKW*WW +: NKW*WW];
    assign req_ready_o = (state == ST_ISSUE && eng_ready_i) ? owner_oh : '0;

    assign rsp_valid_o = (state == ST_WAIT && eng_valid_i) ? owner_oh : '0;
    assign eng_ready_o = (state == ST_WAIT) && rsp_ready_i[owner];
    assign rsp_mode_o  = eng_mode_i;
    assign rsp_ct_o    = eng_ct_i;

endmodule

`default_nettype wire

// File: tb/tb_simon_req_arbiter.sv
// Directed bench for simon_req_arbiter with a behavioural Simon 64/128 engine.
`default_nettype none

module tb_simon_req_arbiter;

    localparam int NREQ = 4;
    localparam int WW   = 32;
    localparam int NKW  = 4;

    localparam logic [127:0] KEY = 128'h1b1a1918_13121110_0b0a0908_03020100;
    localparam logic [63:0]  PT  = 64'h656b696c_20646e75;
    localparam logic [63:0]  CT  = 64'h44c8fc20_b9dfa07a;

    logic clk = 1'b0;
    logic arst_n;
    logic [NREQ-1:0]        req_valid, req_ready, req_mode, rsp_valid, rsp_ready;
    logic [NREQ*2*WW-1:0]   req_pt;
    logic [NREQ*NKW*WW-1:0] req_key;
    logic                   rsp_mode, eng_valid_o, eng_ready_i, eng_mode_o;
    logic [2*WW-1:0]        rsp_ct, eng_pt_o, eng_ct_i;
    logic [NKW*WW-1:0]      eng_key_o;
    logic                   eng_valid_i, eng_ready_o, eng_mode_i, busy, err;
    logic [1:0]             owner;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    simon_req_arbiter #(.NREQ(NREQ), .WW(WW), .NKW(NKW)) dut (
        .clk(clk), .arst_n(arst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_mode_i(req_mode),
        .req_pt_i(req_pt), .req_key_i(req_key),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_mode_o(rsp_mode), .rsp_ct_o(rsp_ct),
        .eng_valid_o(eng_valid_o), .eng_ready_i(eng_ready_i), .eng_mode_o(eng_mode_o),
        .eng_pt_o(eng_pt_o), .eng_key_o(eng_key_o),
        .eng_valid_i(eng_valid_i), .eng_ready_o(eng_ready_o), .eng_mode_i(eng_mode_i), .eng_ct_i(eng_ct_i),
        .busy_o(busy), .owner_o(owner), .err_o(err)
    );

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] simon_f(input logic [31:0] x);
        return (ror(x, 31) & ror(x, 24)) ^ ror(x, 30);
    endfunction

    // Simon 64/128: 44 rounds, z3 constant sequence.
    function automatic logic [63:0] simon(input logic [63:0] blk, input logic [127:0] key, input logic dec);
        logic [31:0] k [44];
        logic [61:0] z;
        logic [31:0] x, y, t;
        z = 62'b11011011101011000110010111100000010010001010011100110100001111;
        for (int i = 0; i < 4; i++) k[i] = key[32*i +: 32];
        for (int i = 4; i < 44; i++) begin
            t = ror(k[i-1], 3) ^ k[i-3];
            t = t ^ ror(t, 1);
            k[i] = ~k[i-4] ^ t ^ {31'b0, z[61-(i-4)]} ^ 32'd3;
        end
        x = blk[63:32];
        y = blk[31:0];
        if (!dec) begin
            for (int i = 0; i < 44; i++) begin
                t = x; x = y ^ simon_f(x) ^ k[i]; y = t;
            end
        end else begin
            for (int i = 43; i >= 0; i--) begin
                t = y; y = x ^ simon_f(y) ^ k[i]; x = t;
            end
        end
        return {x, y};
    endfunction

    // Behavioural engine: accepts when idle, answers a few cycles later, holds until consumed.
    logic        eng_busy, eng_out_v, eng_inject, eng_m_r, eng_m_out;
    int          eng_cnt;
    logic [63:0]  eng_pt_r, eng_ct_out;
    logic [127:0] eng_key_r;

    assign eng_ready_i = !eng_busy;
    assign eng_valid_i = eng_out_v | eng_inject;
    assign eng_mode_i  = eng_m_out;
    assign eng_ct_i    = eng_ct_out;

    always @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            eng_busy  <= 1'b0;
            eng_out_v <= 1'b0;
            eng_cnt   <= 0;
        end else if (!eng_busy && eng_valid_o) begin
            eng_busy  <= 1'b1;
            eng_cnt   <= 3;
            eng_m_r   <= eng_mode_o;
            eng_pt_r  <= eng_pt_o;
            eng_key_r <= eng_key_o;
        end else if (eng_busy && !eng_out_v) begin
            if (eng_cnt == 0) begin
                eng_out_v  <= 1'b1;
                eng_m_out  <= eng_m_r;
                eng_ct_out <= simon(eng_pt_r, eng_key_r, eng_m_r);
            end else begin
                eng_cnt <= eng_cnt - 1;
            end
        end else if (eng_out_v && eng_ready_o) begin
            eng_out_v <= 1'b0;
            eng_busy  <= 1'b0;
        end
    end

    task automatic set_req(input int i, input logic v, input logic m, input logic [63:0] pt, input logic [127:0] key);
        req_valid[i] = v;
        req_mode[i]  = m;
        req_pt[i*64 +: 64]   = pt;
        req_key[i*128 +: 128] = key;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        arst_n = 1'b0;
        req_valid = '0;
        rsp_ready = '1;
        eng_inject = 1'b0;
        repeat (2) @(negedge clk);
        arst_n = 1'b1;
    endtask

    // Drives one request, drops valid once accepted and captures the response.
    task automatic run_one(input int i, input logic m, input logic [63:0] pt, input logic [127:0] key,
                           output logic [3:0] vv, output logic [63:0] ct, output logic mo,
                           output logic [1:0] own, output bit to);
        bit accepted;
        accepted = 0;
        to = 1;
        vv = '0; ct = '0; mo = 1'b0; own = '0;
        rsp_ready = '1;
        set_req(i, 1'b1, m, pt, key);
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (!accepted && req_ready[i]) begin
                accepted = 1;
                @(posedge clk);
                #1 req_valid[i] = 1'b0;
            end else if (rsp_valid != '0) begin
                vv = rsp_valid; ct = rsp_ct; mo = rsp_mode; own = owner; to = 0;
                @(posedge clk);
                #1;
                break;
            end
        end
        req_valid[i] = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        vectors++;
        if ({busy, owner, err} !== 4'b0) begin
            miscompares++;
            $display("FAIL reset_state: busy/owner/err got %b/%0d/%b want 0/0/0", busy, owner, err);
        end
        vectors++;
        if ({rsp_valid, req_ready, eng_valid_o, eng_ready_o} !== 10'b0) begin
            miscompares++;
            $display("FAIL reset_handshakes: rsp_valid %b req_ready %b eng_valid %b eng_ready %b want all 0",
                     rsp_valid, req_ready, eng_valid_o, eng_ready_o);
        end
    endtask

    task automatic test_encrypt();
        logic [3:0] vv; logic [63:0] ct; logic mo; logic [1:0] own; bit to;
        run_one(2, 1'b0, PT, KEY, vv, ct, mo, own, to);
        vectors++;
        if (to) begin miscompares++; $display("FAIL enc_timeout: no response got 1 want 0"); end
        vectors++;
        if (vv !== 4'b0100) begin miscompares++; $display("FAIL enc_rsp_valid: got %b want 0100", vv); end
        vectors++;
        if (ct !== CT) begin miscompares++; $display("FAIL enc_ct: got %h want %h", ct, CT); end
        vectors++;
        if (mo !== 1'b0 || own !== 2'd2) begin
            miscompares++; $display("FAIL enc_mode_owner: got %b/%0d want 0/2", mo, own);
        end
    endtask

    task automatic test_decrypt();
        logic [3:0] vv; logic [63:0] ct; logic mo; logic [1:0] own; bit to;
        run_one(0, 1'b1, CT, KEY, vv, ct, mo, own, to);
        vectors++;
        if (to || vv !== 4'b0001) begin
            miscompares++; $display("FAIL dec_rsp_valid: got %b (timeout %0d) want 0001", vv, to);
        end
        vectors++;
        if (ct !== PT) begin miscompares++; $display("FAIL dec_pt: got %h want %h", ct, PT); end
        vectors++;
        if (mo !== 1'b1) begin miscompares++; $display("FAIL dec_mode: got %b want 1", mo); end
    endtask

    task automatic test_round_robin();
        int exp_order[5] = '{0, 1, 2, 3, 0};
        logic [63:0] pts[4];
        logic [63:0] exp_ct;
        bit seen;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            pts[i] = 64'h1000_0000_0000_0000 * (i + 1) + 64'h0123_4567;
            set_req(i, 1'b1, 1'b0, pts[i], KEY);
        end
        for (int n = 0; n < 5; n++) begin
            seen = 0;
            for (int c = 0; c < 100 && !seen; c++) begin
                @(negedge clk);
                if (rsp_valid != '0) begin
                    seen = 1;
                    exp_ct = simon(pts[exp_order[n]], KEY, 1'b0);
                    vectors++;
                    if (owner !== 2'(exp_order[n]) || rsp_valid !== 4'(1 << exp_order[n])) begin
                        miscompares++;
                        $display("FAIL rr_grant%0d: owner %0d rsp_valid %b want owner %0d", n, owner, rsp_valid, exp_order[n]);
                    end
                    vectors++;
                    if (rsp_ct !== exp_ct) begin
                        miscompares++; $display("FAIL rr_ct%0d: got %h want %h", n, rsp_ct, exp_ct);
                    end
                    @(posedge clk);
                    #1;
                end
            end
            if (!seen) begin
                vectors++; miscompares++;
                $display("FAIL rr_timeout%0d: response missing got 0 want 1", n);
            end
        end
        req_valid = '0;
        vectors++;
        if (err !== 1'b0) begin miscompares++; $display("FAIL rr_err: got %b want 0", err); end
    endtask

    task automatic test_stall();
        logic [3:0] v0; logic [63:0] c0; bit seen; bit accepted;
        logic [63:0] pt1;
        pt1 = 64'hdead_beef_0bad_f00d;
        rsp_ready = '0;
        set_req(1, 1'b1, 1'b0, pt1, KEY);
        seen = 0; accepted = 0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk);
            if (!accepted && req_ready[1]) begin
                accepted = 1;
                @(posedge clk);
                #1 req_valid[1] = 1'b0;
                set_req(3, 1'b1, 1'b0, PT, KEY);
            end else if (rsp_valid != '0) begin
                seen = 1;
            end
        end
        v0 = rsp_valid; c0 = rsp_ct;
        vectors++;
        if (!seen || v0 !== 4'b0010 || c0 !== simon(pt1, KEY, 1'b0)) begin
            miscompares++; $display("FAIL stall_first: rsp_valid %b ct %h want 0010 / %h", v0, c0, simon(pt1, KEY, 1'b0));
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            vectors++;
            if (rsp_valid !== v0 || rsp_ct !== c0 || eng_ready_o !== 1'b0 || owner !== 2'd1 || eng_valid_o !== 1'b0) begin
                miscompares++;
                $display("FAIL stall_cycle%0d: rsp_valid %b ct %h eng_ready %b owner %0d eng_valid %b want %b %h 0 1 0",
                         c, rsp_valid, rsp_ct, eng_ready_o, owner, eng_valid_o, v0, c0);
            end
        end
        req_valid[3] = 1'b0;
        rsp_ready[1] = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = '1;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL stall_release: busy got %b want 0", busy); end
    endtask

    task automatic test_err();
        @(negedge clk);
        vectors++;
        if (err !== 1'b0 || busy !== 1'b0) begin
            miscompares++; $display("FAIL err_pre: err %b busy %b want 0 0", err, busy);
        end
        eng_inject = 1'b1;
        @(posedge clk);
        #1 eng_inject = 1'b0;
        vectors++;
        if (err !== 1'b1) begin miscompares++; $display("FAIL err_rise: got %b want 1", err); end
        vectors++;
        if (rsp_valid !== 4'b0 || busy !== 1'b0) begin
            miscompares++; $display("FAIL err_ignored: rsp_valid %b busy %b want 0000 0", rsp_valid, busy);
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            vectors++;
            if (err !== 1'b1) begin miscompares++; $display("FAIL err_sticky%0d: got %b want 1", c, err); end
        end
        arst_n = 1'b0;
        #1;
        vectors++;
        if (err !== 1'b0) begin miscompares++; $display("FAIL err_clear: got %b want 0", err); end
        @(negedge clk);
        arst_n = 1'b1;
    endtask

    task automatic test_reset_mid();
        logic [3:0] vv; logic [63:0] ct; logic mo; logic [1:0] own; bit to; bit seen; bit accepted;
        logic [63:0] pt1;
        rsp_ready = '0;
        set_req(2, 1'b1, 1'b0, PT, KEY);
        seen = 0; accepted = 0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk);
            if (!accepted && req_ready[2]) begin
                accepted = 1;
                @(posedge clk);
                #1 req_valid[2] = 1'b0;
            end else if (rsp_valid != '0) begin
                seen = 1;
            end
        end
        vectors++;
        if (!seen || owner !== 2'd2) begin
            miscompares++; $display("FAIL rstmid_wait: reached %0d owner %0d want 1 2", seen, owner);
        end
        arst_n = 1'b0;
        #1;
        vectors++;
        if ({busy, owner, err, rsp_valid, req_ready, eng_valid_o, eng_ready_o} !== 14'b0) begin
            miscompares++;
            $display("FAIL rstmid_outputs: busy %b owner %0d err %b rsp_valid %b req_ready %b eng_valid %b eng_ready %b want all 0",
                     busy, owner, err, rsp_valid, req_ready, eng_valid_o, eng_ready_o);
        end
        @(negedge clk);
        arst_n = 1'b1;
        pt1 = 64'h0123_4567_89ab_cdef;
        run_one(1, 1'b0, pt1, KEY, vv, ct, mo, own, to);
        vectors++;
        if (to || own !== 2'd1 || vv !== 4'b0010) begin
            miscompares++; $display("FAIL rstmid_grant: owner %0d rsp_valid %b timeout %0d want 1 0010 0", own, vv, to);
        end
        vectors++;
        if (ct !== simon(pt1, KEY, 1'b0)) begin
            miscompares++; $display("FAIL rstmid_ct: got %h want %h", ct, simon(pt1, KEY, 1'b0));
        end
    endtask

    initial begin
        arst_n = 1'b0;
        req_valid = '0; req_mode = '0; req_pt = '0; req_key = '0;
        rsp_ready = '1; eng_inject = 1'b0;
        test_reset();
        test_encrypt();
        test_decrypt();
        test_round_robin();
        test_stall();
        test_err();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
